adder_share_arbiter: RTL and testbench
======================================

Name: adder_share_arbiter

Overview:
- Round-robin scheduler that shares one 16-bit adder datapath among NUM_REQ requesters.
- Each granted request is a 32-bit add, run as two sequenced 16-bit passes: low half, then high half with the low-half carry.
- Sits between the lab's requesting units and the single 16-bit carry-lookahead adder datapath. The block owns the operand muxing, the carry between the two passes, and the result registers.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- IDW, $clog2(NUM_REQ), width of the grant-ID field; derived, never overridden.

Ports:
- Clk  input  1  sole clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Req  input  NUM_REQ  per-requester request level; held high until that requester's Done.
- OpA  input  NUM_REQ*32  operand A, flattened; requester i uses bits [32i+31:32i].
- OpB  input  NUM_REQ*32  operand B, same packing as OpA.
- Done  output  NUM_REQ  one-hot, one-cycle pulse marking completion for the granted requester.
- Result  output  32  sum of the most recent completed operation.
- CO  output  1  carry out of bit 31 of the most recent completed operation.
- Busy  output  1  high in every state except IDLE.
- GrantId  output  IDW  index of the current or last granted requester.

Behaviour:
- Reset (synchronous, takes effect on the edge where Reset=1):
  - State = IDLE; Done=0, Result=0, CO=0, Busy=0, GrantId=0.
  - Round-robin pointer reset so requester 0 has highest priority.
  - An operation in flight is abandoned with no Done pulse.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE: if any Req bit is high, select the first set bit searching upward from pointer, wrapping modulo NUM_REQ. On the edge: capture that requester's OpA/OpB into internal registers, set GrantId, go to LO. If no Req bit is set, stay in IDLE.
  - LO: add the captured A[15:0] and B[15:0] with carry-in 0. On the edge: register the low sum and carry c16, go to HI.
  - HI: add A[31:16] and B[31:16] with carry-in c16. On the edge: register the high sum, set Result = {hi, lo} and CO = carry out, go to DONE.
  - DONE: Done[GrantId]=1 for exactly this cycle. On the edge: pointer = (GrantId+1) mod NUM_REQ, go to IDLE.
- Timing:
  - With the request sampled in cycle 0 (IDLE), Done is high in cycle 3.
  - Maximum throughput is one operation per 4 cycles.
  - Result and CO are valid from cycle 3 and hold until the next DONE or Reset.
- Operands are sampled only on the grant edge. Later changes to OpA, OpB or Req during LO, HI or DONE have no effect.
- Req dropped after grant: the operation still completes and Done still pulses.
- Req still high during the DONE cycle: the requester is re-eligible in the next IDLE, but the pointer has moved past it, so any other pending requester wins first.
- Simultaneous requests: exactly one grant per IDLE cycle. No requester waits more than NUM_REQ-1 operations.
- Arithmetic is modulo 2^32; CO reports the unsigned carry. The two-pass sum equals the 32-bit sum for all operands, including a carry ripple such as 0x0000FFFF + 1.
- Reset asserted in IDLE with Req high: no grant that cycle; arbitration resumes the cycle after Reset falls.

Optional Feature:
- Macro: ADDER_SUB_EN.
- Defined:
  - Adds input Sub (NUM_REQ bits); Sub[i] is captured with requester i's operands on the grant edge.
  - When the captured Sub is 1, the LO pass uses ~B[15:0] with carry-in 1, and the HI pass uses ~B[31:16] with carry-in c16.
  - Result is then A−B modulo 2^32, and CO=1 means no borrow.
- Not defined: the Sub port does not exist and every operation is A+B.

Test Plan:
- Reset with Req=4'b0000 → Done=0, Result=0, CO=0, Busy=0, GrantId=0; then Req[0]=1, OpA0=0x0000FFFF, OpB0=0x00000001 → Done=4'b0001 in cycle 3, Result=0x00010000, CO=0.
- Req[2]=1, OpA2=0xFFFFFFFF, OpB2=0x00000001 → GrantId=2, Result=0x00000000, CO=1, Done=4'b0100 exactly one cycle.
- Req=4'b1111 held continuously from reset → grant order 0,1,2,3,0; Done pulses 4 cycles apart; Busy drops for exactly one IDLE cycle between operations.
- Grant requester 1 with OpA1=0x12345678, OpB1=0x11111111, then change OpA1 to 0 and drop Req[1] during LO → Result=0x23456789, Done=4'b0010.
- Assert Reset during HI of an operation → next cycle state IDLE, Done=0, Result=0, CO=0; the interrupted operation produces no Done pulse.
- With ADDER_SUB_EN: Req[3]=1, Sub[3]=1, OpA3=0x00000005, OpB3=0x00000007 → Result=0xFFFFFFFE, CO=0; with OpA3=7, OpB3=5 → Result=0x00000002, CO=1.

Source files
------------

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
// Round-robin scheduler that shares one 16-bit adder among NUM_REQ requesters.
// Each granted 32-bit add runs as two 16-bit passes (low, then high with carry).
// Optional feature macro: ADDER_SUB_EN adds a per-requester Sub input that
// turns the operation into A-B (CO=1 means no borrow).
module adder_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [NUM_REQ-1:0]      Req,
    input  logic [NUM_REQ*32-1:0]   OpA,
    input  logic [NUM_REQ*32-1:0]   OpB,
`ifdef ADDER_SUB_EN
    input  logic [NUM_REQ-1:0]      Sub,
`endif
    output logic [NUM_REQ-1:0]      Done,
    output logic [31:0]             Result,
    output logic                    CO,
    output logic                    Busy,
    output logic [IDW-1:0]          GrantId
);

    // one extra bit so pointer+offset can exceed NUM_REQ-1 before wrapping
    localparam int             PW        = IDW + 1;
    localparam logic [PW-1:0]  NUM_REQ_P = PW'(NUM_REQ);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [IDW-1:0]     ptr_reg;
    logic [IDW-1:0]     ptr_next;
    logic [IDW-1:0]     grant_reg;
    logic [31:0]        a_reg;
    logic [31:0]        b_reg;
    logic [15:0]        lo_reg;
    logic               c16_reg;
    logic [31:0]        result_reg;
    logic               co_reg;
`ifdef ADDER_SUB_EN
    logic               sub_reg;
`endif

    logic [31:0]        op_a_arr [NUM_REQ];
    logic [31:0]        op_b_arr [NUM_REQ];
    logic [NUM_REQ-1:0] req_rot;
    logic               grant_found;
    logic [PW-1:0]      grant_offset;
    logic [PW-1:0]      grant_sum;
    logic [IDW-1:0]     grant_idx;
    logic [PW-1:0]      ptr_sum;
    logic [15:0]        add_a;
    logic [15:0]        add_b;
    logic               add_cin;
    logic [16:0]        add_sum;
    logic               busy_c;
    logic               done_en;

    // unpack the flattened operand buses and drive the one-hot Done vector
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign op_a_arr[gi] = OpA[32*gi +: 32];
        assign op_b_arr[gi] = OpB[32*gi +: 32];
        assign Done[gi]     = done_en && (grant_reg == IDW'(gi));
    end

    // rotate requests so bit 0 is the requester at the round-robin pointer
    assign req_rot = NUM_REQ'({Req, Req} >> ptr_reg);

    // round-robin pick: lowest set rotated bit, mapped back to an absolute index
    always_comb begin
        grant_found  = 1'b0;
        grant_offset = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                grant_found  = 1'b1;
                grant_offset = PW'(k);
            end
        end
        grant_sum = {1'b0, ptr_reg} + grant_offset;
        if (grant_sum >= NUM_REQ_P) begin
            grant_sum = grant_sum - NUM_REQ_P;
        end
        grant_idx = grant_sum[IDW-1:0];
    end

    // pointer moves to the requester just after the one being completed
    always_comb begin
        ptr_sum = {1'b0, grant_reg} + PW'(1);
        if (ptr_sum >= NUM_REQ_P) begin
            ptr_sum = '0;
        end
        ptr_next = ptr_sum[IDW-1:0];
    end

    // shared 16-bit adder: low half with cin 0 in LO, high half with c16 in HI
    always_comb begin
        add_a   = (state_reg == HI) ? a_reg[31:16] : a_reg[15:0];
        add_b   = (state_reg == HI) ? b_reg[31:16] : b_reg[15:0];
        add_cin = (state_reg == HI) ? c16_reg : 1'b0;
`ifdef ADDER_SUB_EN
        if (sub_reg) begin
            add_b = ~add_b;
            if (state_reg != HI) begin
                add_cin = 1'b1;
            end
        end
`endif
        add_sum = {1'b0, add_a} + {1'b0, add_b} + {16'b0, add_cin};
    end

    // FSM state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_found) state_next = LO;
            LO:      state_next = HI;
            HI:      state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy_c  = (state_reg != IDLE);
        done_en = (state_reg == DONE);
    end

    // datapath: operand capture, pass results, pointer update
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr_reg    <= '0;
            grant_reg  <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            lo_reg     <= '0;
            c16_reg    <= 1'b0;
            result_reg <= '0;
            co_reg     <= 1'b0;
`ifdef ADDER_SUB_EN
            sub_reg    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_found) begin
                        a_reg     <= op_a_arr[grant_idx];
                        b_reg     <= op_b_arr[grant_idx];
                        grant_reg <= grant_idx;
`ifdef ADDER_SUB_EN
                        sub_reg   <= Sub[grant_idx];
`endif
                    end
                end
                LO: begin
                    lo_reg  <= add_sum[15:0];
                    c16_reg <= add_sum[16];
                end
                HI: begin
                    result_reg <= {add_sum[15:0], lo_reg};
                    co_reg     <= add_sum[16];
                end
                DONE: begin
                    ptr_reg <= ptr_next;
                end
                default: ;
            endcase
        end
    end

    assign Result  = result_reg;
    assign CO      = co_reg;
    assign Busy    = busy_c;
    assign GrantId = grant_reg;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Testbench for adder_share_arbiter: directed scenarios plus randomized
// traffic, checked by a scoreboard fed from a transaction-level reference model.
module tb_adder_share_arbiter;

    localparam int N = 4;

    logic           Clk = 1'b0;
    logic           Reset;
    logic [N-1:0]   Req;
    logic [N*32-1:0] OpA;
    logic [N*32-1:0] OpB;
`ifdef ADDER_SUB_EN
    logic [N-1:0]   Sub;
`endif
    logic [N-1:0]   Done;
    logic [31:0]    Result;
    logic           CO;
    logic           Busy;
    logic [1:0]     GrantId;

    adder_share_arbiter #(.NUM_REQ(N)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Req     (Req),
        .OpA     (OpA),
        .OpB     (OpB),
`ifdef ADDER_SUB_EN
        .Sub     (Sub),
`endif
        .Done    (Done),
        .Result  (Result),
        .CO      (CO),
        .Busy    (Busy),
        .GrantId (GrantId)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        co;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    // reference model state: cycles left in the current operation, pointer,
    // last granted id and the visible result registers
    int          m_cnt = 0;
    int          m_ptr = 0;
    int          m_gid = 0;
    logic [31:0] m_res = '0;
    logic        m_co  = 1'b0;
    logic [31:0] m_fly_res = '0;
    logic        m_fly_co  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge Clk);
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h0000_FFFF;
            2:       return 32'h0000_0000;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // reference model: an operation is granted in an idle cycle to the first
    // requester at or after the pointer, then takes three more cycles
    initial begin : model
        bit          found;
        int          c;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [32:0] s;
        exp_t        e;
        forever begin
            @(posedge Clk);
            if (Reset) begin
                m_cnt = 0;
                m_ptr = 0;
                m_gid = 0;
                m_res = '0;
                m_co  = 1'b0;
                sbq.delete();
            end else if (m_cnt > 0) begin
                if (m_cnt == 2) begin
                    m_res = m_fly_res;
                    m_co  = m_fly_co;
                end
                m_cnt--;
            end else begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    c = (m_ptr + k) % N;
                    if (!found && Req[c]) begin
                        found = 1'b1;
                        a = OpA[32*c +: 32];
                        b = OpB[32*c +: 32];
`ifdef ADDER_SUB_EN
                        sub = Sub[c];
`else
                        sub = 1'b0;
`endif
                        if (sub) s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                        else     s = {1'b0, a} + {1'b0, b};
                        e.id  = c;
                        e.res = s[31:0];
                        e.co  = s[32];
                        sbq.push_back(e);
                        m_fly_res = s[31:0];
                        m_fly_co  = s[32];
                        m_gid = c;
                        m_ptr = (c + 1) % N;
                        m_cnt = 3;
                    end
                end
            end
        end
    end

    // monitor: per-cycle status checks, scoreboard pop on every Done pulse
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge Clk);
            chk("busy", 32'(Busy), 32'(m_cnt != 0));
            chk("grant_id", 32'(GrantId), 32'(m_gid));
            chk("result_hold", Result, m_res);
            chk("co_hold", 32'(CO), 32'(m_co));
            chk("done_timing", 32'(Done != '0), 32'(m_cnt == 1));
            if (Done != '0) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_done: got done=%b expected no pending op at %0t", Done, $time);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_done_onehot", 32'(Done), 32'(1) << e.id);
                    chk("sb_result", Result, e.res);
                    chk("sb_co", 32'(CO), 32'(e.co));
                end
            end
        end
    end

    initial begin : stimulus
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};
        Reset = 1'b1;
        Req   = '0;
        OpA   = '0;
        OpB   = '0;
`ifdef ADDER_SUB_EN
        Sub   = '0;
`endif
        tick(2);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_result", Result, 32'd0);
        chk("rst_co", 32'(CO), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_gid", 32'(GrantId), 32'd0);
        Reset = 1'b0;

        // low-half carry ripples into the high half
        Req[0] = 1'b1;
        OpA[31:0] = 32'h0000_FFFF;
        OpB[31:0] = 32'h0000_0001;
        tick(3);
        chk("t1_done", 32'(Done), 32'h1);
        chk("t1_result", Result, 32'h0001_0000);
        chk("t1_co", 32'(CO), 32'd0);
        Req[0] = 1'b0;
        tick(1);

        // full 32-bit wrap with carry out
        Req[2] = 1'b1;
        OpA[95:64] = 32'hFFFF_FFFF;
        OpB[95:64] = 32'h0000_0001;
        tick(3);
        chk("t2_done", 32'(Done), 32'h4);
        chk("t2_gid", 32'(GrantId), 32'd2);
        chk("t2_result", Result, 32'h0000_0000);
        chk("t2_co", 32'(CO), 32'd1);
        Req[2] = 1'b0;
        tick(1);
        chk("t2_done_one_cycle", 32'(Done), 32'd0);

        // all requesters held high from reset: strict rotation
        Reset = 1'b1;
        Req   = '1;
        for (int i = 0; i < N; i++) begin
            OpA[32*i +: 32] = $urandom;
            OpB[32*i +: 32] = $urandom;
        end
        tick(2);
        Reset = 1'b0;
        tick(3);
        for (int i = 0; i < 5; i++) begin
            chk("t3_order_gid", 32'(GrantId), 32'(exp_order[i]));
            chk("t3_order_done", 32'(Done), 32'(1) << exp_order[i]);
            if (i < 4) begin
                tick(1);
                chk("t3_idle_gap", 32'(Busy), 32'd0);
                tick(1);
                chk("t3_busy_again", 32'(Busy), 32'd1);
                tick(2);
            end
        end
        Req = '0;
        tick(2);

        // operands and request changed after grant are ignored
        Req[1] = 1'b1;
        OpA[63:32] = 32'h1234_5678;
        OpB[63:32] = 32'h1111_1111;
        tick(1);
        OpA[63:32] = 32'h0;
        Req[1] = 1'b0;
        tick(2);
        chk("t4_done", 32'(Done), 32'h2);
        chk("t4_result", Result, 32'h2345_6789);
        tick(1);

        // reset during HI abandons the operation
        Req[0] = 1'b1;
        OpA[31:0] = $urandom;
        OpB[31:0] = $urandom;
        tick(2);
        Reset = 1'b1;
        Req   = '0;
        tick(1);
        chk("t5_done", 32'(Done), 32'd0);
        chk("t5_result", Result, 32'd0);
        chk("t5_co", 32'(CO), 32'd0);
        chk("t5_busy", 32'(Busy), 32'd0);
        Reset = 1'b0;
        tick(6);

`ifdef ADDER_SUB_EN
        Req[3] = 1'b1;
        Sub[3] = 1'b1;
        OpA[127:96] = 32'd5;
        OpB[127:96] = 32'd7;
        tick(3);
        chk("t6_sub_result", Result, 32'hFFFF_FFFE);
        chk("t6_sub_co", 32'(CO), 32'd0);
        Req[3] = 1'b0;
        tick(1);
        Req[3] = 1'b1;
        OpA[127:96] = 32'd7;
        OpB[127:96] = 32'd5;
        tick(3);
        chk("t6_sub2_result", Result, 32'h0000_0002);
        chk("t6_sub2_co", 32'(CO), 32'd1);
        Req = '0;
        Sub = '0;
        tick(1);
`endif

        // randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (Req[i] && Done[i]) begin
                    Req[i] = ($urandom_range(0, 3) == 0);
                end else if (!Req[i] && $urandom_range(0, 2) == 0) begin
                    Req[i] = 1'b1;
                    OpA[32*i +: 32] = rnd32();
                    OpB[32*i +: 32] = rnd32();
`ifdef ADDER_SUB_EN
                    Sub[i] = $urandom_range(0, 1) == 1;
`endif
                end
                if ($urandom_range(0, 7) == 0) begin
                    OpA[32*i +: 32] = rnd32();
                    OpB[32*i +: 32] = rnd32();
                end
            end
            Reset = ($urandom_range(0, 499) == 0);
            tick(1);
        end
        Reset = 1'b0;
        Req   = '0;
        tick(10);
        chk("sb_drain", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
